// File: rtl/du_dump_receiver.sv
// Reassembles the debug unit's UART dump (PC, register bank, data memory) into
// 32-bit words tagged with section and index. Optional XOR trailer: DU_DUMP_CHECKSUM_EN.
module du_dump_receiver #(
  parameter int BYTE           = 8,
  parameter int DWORD          = 32,
  parameter int RB_ADDR_SIZE   = 5,
  parameter int ADDR           = 5,
  parameter int TIMEOUT_CYCLES = 1000000,
  localparam int IDX_W = (RB_ADDR_SIZE > ADDR) ? RB_ADDR_SIZE : ADDR
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_arm,
  input  logic [BYTE-1:0]  i_rx_data,
  input  logic             i_rx_done,
  output logic             o_word_valid,
  output logic [DWORD-1:0] o_word,
  output logic [1:0]       o_section,
  output logic [IDX_W-1:0] o_index,
  output logic             o_busy,
  output logic             o_frame_done,
  output logic             o_timeout_error,
  output logic             o_frame_error
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] REG_LAST = IDX_W'((1 << RB_ADDR_SIZE) - 1);
  localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'((1 << ADDR) - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] SEC_PC  = 2'd0;
  localparam logic [1:0] SEC_REG = 2'd1;
  localparam logic [1:0] SEC_MEM = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_PC,
    S_REGS,
    S_MEM,
`ifdef DU_DUMP_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE
  } state_t;

  state_t           state;
  logic [1:0]       byte_cnt;
  logic [IDX_W-1:0] index;
  logic [TO_W-1:0]  to_cnt;
  logic [DWORD-1:0] word_buf;
  logic [DWORD-1:0] word_next;
  logic             in_check;

`ifdef DU_DUMP_CHECKSUM_EN
  logic [BYTE-1:0]  csum;
  assign in_check = (state == S_CHECK);
`else
  assign in_check      = 1'b0;
  assign o_frame_error = 1'b0;
`endif

  // NOTE: give every always_comb output a default first; a path that leaves it
  // unassigned makes synthesis infer a latch.
  always_comb begin
    word_next = word_buf;
    word_next[byte_cnt*BYTE +: BYTE] = i_rx_data;
  end

  // NOTE: state lives in always_ff and is updated with <= only, so every branch
  // reads the pre-edge values regardless of statement order.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state           <= S_IDLE;
      byte_cnt        <= '0;
      index           <= '0;
      to_cnt          <= '0;
      word_buf        <= '0;
      o_word_valid    <= 1'b0;
      o_word          <= '0;
      o_section       <= '0;
      o_index         <= '0;
      o_busy          <= 1'b0;
      o_frame_done    <= 1'b0;
      o_timeout_error <= 1'b0;
`ifdef DU_DUMP_CHECKSUM_EN
      csum            <= '0;
      o_frame_error   <= 1'b0;
`endif
    end else begin
      o_word_valid <= 1'b0;
      o_frame_done <= 1'b0;
      if (i_arm) begin
        // Arm restarts from scratch in any state and drops a coincident byte.
        state           <= S_ARMED;
        o_busy          <= 1'b1;
        byte_cnt        <= '0;
        index           <= '0;
        to_cnt          <= '0;
        o_timeout_error <= 1'b0;
`ifdef DU_DUMP_CHECKSUM_EN
        csum            <= '0;
        o_frame_error   <= 1'b0;
`endif
      end else begin
        case (state)
          S_IDLE, S_DONE: state <= S_IDLE;
          default: begin
            if (!i_rx_done) begin
              // The gap timer only runs once the first byte of the frame is in.
              if (state != S_ARMED) begin
                if (to_cnt == TO_LAST) begin
                  o_timeout_error <= 1'b1;
                  o_busy          <= 1'b0;
                  state           <= S_IDLE;
                  to_cnt          <= '0;
                  byte_cnt        <= '0;
                  index           <= '0;
                end else begin
                  to_cnt <= to_cnt + 1'b1;
                end
              end
            end else begin
              to_cnt <= '0;
`ifdef DU_DUMP_CHECKSUM_EN
              csum <= csum ^ i_rx_data;
`endif
              if (in_check) begin
`ifdef DU_DUMP_CHECKSUM_EN
                if (csum != i_rx_data) o_frame_error <= 1'b1;
`endif
                o_frame_done <= 1'b1;
                o_busy       <= 1'b0;
                state        <= S_DONE;
              end else begin
                word_buf <= word_next;
                byte_cnt <= byte_cnt + 1'b1;
                if (state == S_ARMED) state <= S_PC;
                if (byte_cnt == 2'd3) begin
                  o_word_valid <= 1'b1;
                  o_word       <= word_next;
                  o_index      <= index;
                  case (state)
                    S_PC: begin
                      o_section <= SEC_PC;
                      state     <= S_REGS;
                      index     <= '0;
                    end
                    S_REGS: begin
                      o_section <= SEC_REG;
                      if (index == REG_LAST) begin
                        state <= S_MEM;
                        index <= '0;
                      end else begin
                        index <= index + 1'b1;
                      end
                    end
                    S_MEM: begin
                      o_section <= SEC_MEM;
                      if (index == MEM_LAST) begin
                        index <= '0;
`ifdef DU_DUMP_CHECKSUM_EN
                        state <= S_CHECK;
`else
                        o_frame_done <= 1'b1;
                        o_busy       <= 1'b0;
                        state        <= S_DONE;
`endif
                      end else begin
                        index <= index + 1'b1;
                      end
                    end
                    default: ;
                  endcase
                end
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_du_dump_receiver.sv
// Randomized bench for du_dump_receiver: a byte-queue model of the dump frame predicts
// every strobe, flag and busy level; directed sequences pin the model with literal values.
`timescale 1ns/1ps
module tb_du_dump_receiver;

  localparam int RB     = 5;
  localparam int AD     = 5;
  localparam int TO     = 300;
  localparam int NREG   = 1 << RB;
  localparam int NMEM   = 1 << AD;
  localparam int NWORDS = 1 + NREG + NMEM;
  localparam int NB     = 4 * NWORDS;
`ifdef DU_DUMP_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, arm, rx_done;
  logic [7:0]  rx_data;
  logic        o_word_valid, o_busy, o_frame_done, o_timeout_error, o_frame_error;
  logic [31:0] o_word;
  logic [1:0]  o_section;
  logic [4:0]  o_index;

  always #5 clk = ~clk;

  du_dump_receiver #(
    .BYTE(8), .DWORD(32), .RB_ADDR_SIZE(RB), .ADDR(AD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_arm(arm), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .o_word_valid(o_word_valid), .o_word(o_word), .o_section(o_section), .o_index(o_index),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_timeout_error(o_timeout_error),
    .o_frame_error(o_frame_error)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: bytes taken since arm, idle gap length, sticky flags.
  logic [7:0]  mq[$];
  bit          m_active = 0, m_terr = 0, m_ferr = 0, chk_en = 0;
  int          m_idle = 0;
  bit          e_wv = 0, e_fd = 0;
  logic [31:0] e_word = '0;
  logic [1:0]  e_sec = '0;
  logic [4:0]  e_idx = '0;

  always @(posedge clk) begin
    int n, k;
    logic [7:0] x;
    e_wv = 0;
    e_fd = 0;
    if (rst) begin
      m_active = 0; mq.delete(); m_idle = 0; m_terr = 0; m_ferr = 0;
      e_word = '0; e_sec = '0; e_idx = '0; chk_en = 1;
    end else if (arm) begin
      m_active = 1; mq.delete(); m_idle = 0; m_terr = 0; m_ferr = 0;
    end else if (m_active) begin
      if (rx_done) begin
        mq.push_back(rx_data);
        m_idle = 0;
        n = mq.size();
        if (n <= NB && n % 4 == 0) begin
          k = n / 4 - 1;
          e_wv = 1;
          e_word = {mq[n-1], mq[n-2], mq[n-3], mq[n-4]};
          if (k == 0) begin e_sec = 2'd0; e_idx = 5'd0; end
          else if (k <= NREG) begin e_sec = 2'd1; e_idx = 5'(k - 1); end
          else begin e_sec = 2'd2; e_idx = 5'(k - 1 - NREG); end
          if (n == NB && !CK) begin e_fd = 1; m_active = 0; end
        end else if (CK && n == NB + 1) begin
          x = 8'h00;
          for (int i = 0; i < NB; i++) x ^= mq[i];
          if (x != rx_data) m_ferr = 1;
          e_fd = 1;
          m_active = 0;
        end
      end else if (mq.size() > 0) begin
        m_idle++;
        if (m_idle == TO) begin m_terr = 1; m_active = 0; end
      end
    end
  end

  typedef struct packed {
    logic [31:0] w;
    logic [1:0]  s;
    logic [4:0]  i;
    logic        fd;
  } strobe_t;

  strobe_t cap_q[$];
  int      done_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("word_valid", o_word_valid, e_wv);
      check("frame_done", o_frame_done, e_fd);
      check("busy", o_busy, m_active);
      check("timeout_error", o_timeout_error, m_terr);
      check("frame_error", o_frame_error, m_ferr);
      if (e_wv) begin
        check("word", o_word, e_word);
        check("section", o_section, e_sec);
        check("index", o_index, e_idx);
      end
      if (o_word_valid) cap_q.push_back({o_word, o_section, o_index, o_frame_done});
      if (o_frame_done) done_cnt++;
    end
  end

  logic [7:0] tx_q[$];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data = b;
    rx_done = 1'b1;
    tick(1);
    rx_done = 1'b0;
    rx_data = 8'($urandom);
    if (gap > 0) tick(gap);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) tx_q.push_back(w[8*i +: 8]);
  endtask

  task automatic build_plan(input bit bad_ck);
    logic [7:0] x;
    tx_q.delete();
    push_word(32'h0000_0040);
    for (int i = 0; i < NREG; i++) push_word(32'(i));
    for (int i = 0; i < NMEM; i++) push_word(32'hA500_0000 + 32'(i));
    x = 8'h00;
    foreach (tx_q[i]) x ^= tx_q[i];
    if (CK) tx_q.push_back(bad_ck ? ~x : x);
  endtask

  task automatic send_q(input int max_gap);
    foreach (tx_q[i]) send_byte(tx_q[i], $urandom_range(max_gap, 0));
  endtask

  function automatic logic [31:0] plan_word(input int k);
    if (k == 0) return 32'h0000_0040;
    if (k <= NREG) return 32'(k - 1);
    return 32'hA500_0000 + 32'(k - 1 - NREG);
  endfunction

  task automatic check_plan_capture(input string tag);
    check({tag, "_count"}, cap_q.size(), NWORDS);
    for (int k = 0; k < NWORDS && k < cap_q.size(); k++) begin
      check({tag, "_word"}, cap_q[k].w, plan_word(k));
      check({tag, "_sec"}, cap_q[k].s, (k == 0) ? 0 : (k <= NREG) ? 1 : 2);
      check({tag, "_idx"}, cap_q[k].i, (k == 0) ? 0 : (k <= NREG) ? k - 1 : k - 1 - NREG);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, mode, len;
    rst = 1'b1; arm = 1'b0; rx_done = 1'b0; rx_data = 8'h00;
    tick(3);
    @(negedge clk);
    check("rst_word_valid", o_word_valid, 0);
    check("rst_word", o_word, 0);
    check("rst_section", o_section, 0);
    check("rst_index", o_index, 0);
    check("rst_busy", o_busy, 0);
    check("rst_frame_done", o_frame_done, 0);
    check("rst_timeout", o_timeout_error, 0);
    check("rst_frame_error", o_frame_error, 0);
    tick(1);
    rst = 1'b0;

    // Bytes while idle are ignored.
    cap_q.delete();
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 0);
    @(negedge clk);
    check("idle_busy", o_busy, 0);
    check("idle_strobes", cap_q.size(), 0);
    tick(1);

    // One-cycle latency of a word strobe after its 4th byte.
    pulse_arm();
    send_byte(8'h78, 1);
    send_byte(8'h56, 1);
    send_byte(8'h34, 1);
    @(negedge clk);
    check("lat_before", o_word_valid, 0);
    tick(1);
    send_byte(8'h12, 0);
    @(negedge clk);
    check("lat_valid", o_word_valid, 1);
    check("lat_word", o_word, 32'h1234_5678);
    check("lat_section", o_section, 0);
    tick(1);
    @(negedge clk);
    check("lat_single", o_word_valid, 0);
    tick(1);

    // Full frame with the reference pattern.
    build_plan(1'b0);
    pulse_arm();
    cap_q.delete();
    d0 = done_cnt;
    send_q(2);
    tick(2);
    @(negedge clk);
    check_plan_capture("plan");
    check("plan_last_fd", cap_q.size() > 0 ? cap_q[cap_q.size()-1].fd : 1'bx, !CK);
    check("plan_done_count", done_cnt - d0, 1);
    check("plan_busy_after", o_busy, 0);
`ifdef DU_DUMP_CHECKSUM_EN
    check("plan_ck_ok", o_frame_error, 0);
`endif
    tick(1);

    // Gap timeout after 6 bytes: only the PC word comes out.
    pulse_arm();
    cap_q.delete();
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 0);
    repeat (TO - 1) @(posedge clk);
    @(negedge clk);
    check("to_not_yet", o_timeout_error, 0);
    check("to_busy_before", o_busy, 1);
    @(posedge clk);
    @(negedge clk);
    check("to_error", o_timeout_error, 1);
    check("to_busy_after", o_busy, 0);
    check("to_strobes", cap_q.size(), 1);
    check("to_strobe_sec", cap_q.size() > 0 ? cap_q[0].s : 2'bxx, 0);
    tick(1);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 0);
    @(negedge clk);
    check("to_idle_strobes", cap_q.size(), 1);
    check("to_sticky", o_timeout_error, 1);
    tick(1);
    pulse_arm();
    @(negedge clk);
    check("to_rearm_clear", o_timeout_error, 0);
    check("to_rearm_busy", o_busy, 1);
    tick(1);

    // Abort after 100 bytes, re-arm together with a byte that must be dropped.
    d0 = done_cnt;
    for (int i = 0; i < 100; i++) send_byte(8'($urandom), $urandom_range(1, 0));
    arm = 1'b1; rx_done = 1'b1; rx_data = 8'hEE;
    tick(1);
    arm = 1'b0; rx_done = 1'b0;
    cap_q.delete();
    @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    tick(1);
    build_plan(1'b0);
    send_q(1);
    tick(2);
    @(negedge clk);
    check_plan_capture("rearm");
    check("rearm_done_count", done_cnt - d0, 1);
    tick(1);

    // Reset in the middle of a frame.
    pulse_arm();
    for (int i = 0; i < 30; i++) send_byte(8'($urandom), 0);
    cap_q.delete();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", o_busy, 0);
    check("midrst_strobes", cap_q.size(), 0);
    tick(1);

`ifdef DU_DUMP_CHECKSUM_EN
    // Corrupted trailer: flag set, frame_done still pulses.
    build_plan(1'b1);
    pulse_arm();
    d0 = done_cnt;
    send_q(1);
    tick(2);
    @(negedge clk);
    check("ck_bad_flag", o_frame_error, 1);
    check("ck_bad_done", done_cnt - d0, 1);
    tick(1);
`endif

    // Random frames: complete, aborted by re-arm, or stalled into timeout.
    for (int r = 0; r < 8; r++) begin
      pulse_arm();
      mode = $urandom_range(2, 0);
      len = (mode == 0) ? NB + int'(CK) : $urandom_range(NB - 1, 1);
      for (int i = 0; i < len; i++) send_byte(8'($urandom), $urandom_range(2, 0));
      if (mode == 2) tick(TO + 5);
      else tick($urandom_range(4, 0) + 1);
    end

    tick(5);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/du_dump_receiver.md
Name: du_dump_receiver

Overview:
- Receive-side counterpart of the debug unit's dump transmitter.
- Consumes the byte stream the debug unit emits over UART after halt (PC, register bank, data memory) and reassembles it into 32-bit words tagged with section and index.
- Sits on the host/monitor side of a UART receiver: its o_rx_data and o_rx_done_tick drive this block.
- Used by on-board monitors and by system-level benches to check dumps.

Parameters:
- BYTE, 8, UART byte width.
- DWORD, 32, reassembled word width; must equal 4*BYTE.
- RB_ADDR_SIZE, 5, register-bank index width; 2**RB_ADDR_SIZE registers per dump.
- ADDR, 5, data-memory index width; 2**ADDR memory words per dump.
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between bytes inside a frame.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_arm  in  1  one-cycle pulse: expect a new dump frame.
- i_rx_data  in  BYTE  received byte; valid only when i_rx_done=1.
- i_rx_done  in  1  one-cycle strobe per received byte.
- o_word_valid  out  1  one-cycle strobe: o_word, o_section and o_index are valid.
- o_word  out  DWORD  reassembled word.
- o_section  out  2  0=PC, 1=register, 2=memory, 3=reserved (never emitted).
- o_index  out  max(RB_ADDR_SIZE,ADDR)  word index within its section; 0 for PC.
- o_busy  out  1  high from arm until frame end or abort.
- o_frame_done  out  1  one-cycle pulse when the last word of the frame has been emitted.
- o_timeout_error  out  1  sticky; cleared by i_arm or reset.
- o_frame_error  out  1  sticky checksum mismatch; exists only with DU_DUMP_CHECKSUM_EN, otherwise tied 0.

Behaviour:
- Frame format:
  - PC word.
  - Then 2**RB_ADDR_SIZE register words, index 0 upward.
  - Then 2**ADDR memory words, index 0 upward.
  - Each word is 4 bytes, least significant byte first.
  - Defaults give 65 words / 260 bytes.
- Reset: state IDLE; all outputs 0; byte counter, word index and timeout counter cleared.
- States: IDLE, ARMED, PC, REGS, MEM, (CHECK), DONE.
  - IDLE: i_rx_done is ignored. i_arm -> ARMED and clears the sticky errors.
  - ARMED: o_busy=1; the timeout is not running. The first i_rx_done -> PC, and that byte is byte 0.
  - PC / REGS / MEM: each i_rx_done shifts the byte into lane byte_cnt. byte_cnt wraps 3->0.
  - On the 4th byte: the next cycle drives o_word_valid=1 with the full word, the current section and the current index (registered, latency 1 cycle from that i_rx_done). The index then increments.
  - Section transitions: PC -> REGS after 1 word. REGS -> MEM after index 2**RB_ADDR_SIZE-1, with the index reset to 0. MEM -> DONE after index 2**ADDR-1 (-> CHECK with the option).
  - DONE: o_frame_done=1 for one cycle, coincident with the final o_word_valid; o_busy drops the same cycle; next state IDLE.
- Timeout:
  - In PC/REGS/MEM/CHECK, the counter increments every cycle and clears on i_rx_done.
  - Reaching TIMEOUT_CYCLES sets o_timeout_error=1 and moves to IDLE.
  - No partial word is emitted; o_busy=0 next cycle.
- i_arm while busy: the frame is aborted and restarted in ARMED. Counters are cleared; o_timeout_error is cleared; no o_frame_done is emitted.
- i_arm and i_rx_done in the same cycle: the arm wins and the byte is discarded.
- Reset mid-frame: immediate return to IDLE; no strobes.
- At most one o_word_valid per 4 bytes.
- The block has no flow control: the consumer must accept every strobe.

Optional Feature:
- Macro DU_DUMP_CHECKSUM_EN.
- Enabled:
  - The frame carries one extra trailing byte, the XOR of all preceding frame bytes.
  - After the last memory word the FSM enters CHECK and waits for that byte (the timeout applies).
  - Mismatch sets o_frame_error.
  - o_frame_done pulses in the cycle after the checksum byte regardless of the result.
  - Frame length is 261 bytes with defaults.
- Disabled: no CHECK state, o_frame_error=0, o_frame_done as above.

Test Plan:
- Reset, arm, send 260 bytes; PC=0x0000_0040, reg[i]=i, mem[i]=0xA5000000+i -> 65 strobes in order: section 0 idx 0 word 0x40; section 1 idx 0..31; section 2 idx 0..31 with matching data; o_frame_done with the last strobe; o_busy 0 after.
- Bytes 0x78,0x56,0x34,0x12 -> o_word=0x12345678 exactly 1 cycle after the 4th i_rx_done.
- Bytes sent while in IDLE (not armed) -> no strobes, o_busy=0.
- Arm, send 6 bytes, stall TIMEOUT_CYCLES -> o_timeout_error=1, one strobe only (PC), state IDLE; re-arm clears the error.
- Arm, send 100 bytes, arm again, send a full frame -> first partial frame produces no o_frame_done; second frame decodes from PC; i_arm coincident with i_rx_done drops that byte.
- With DU_DUMP_CHECKSUM_EN: full frame plus correct XOR -> o_frame_error=0; corrupt the checksum -> o_frame_error=1 and o_frame_done still pulses.
